// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, read-data source and latched request.
package dmem_pkg;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_MMIO} rd_src_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } req_t;
endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with four independent byte lanes and a registered read.
module dmem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q_reg;

    always_ff @(posedge clk) begin
      if (we && be[gi]) mem[addr] <= wdata[8*gi +: 8];
      if (re) q_reg <= mem[addr];
    end

    assign rdata[8*gi +: 8] = q_reg;
  end
endmodule

// File: rtl/dmem_resp.sv
// Target end of the core data-memory req/ready port: one access at a time, WAIT_CYC wait states.
// Define DMEM_MMIO_EN to add a free-running cycle counter readable at MMIO_BASE.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h0000_1000,
  parameter int          DEPTH     = 1024,
  parameter int          WAIT_CYC  = 0,
  parameter logic [31:0] MMIO_BASE = 32'h0000_F000
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] d_addr,
  input  logic        d_wr_req,
  output logic        d_wr_ready,
  input  logic        d_rd_req,
  output logic        d_rd_ready,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wr_data,
  output logic [31:0] d_rd_data,
  output logic        err_oor
);
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(4 * DEPTH);

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] cnt_reg;
  req_t              req_reg;
  rd_src_t           rd_src_reg;
  logic              err_reg;

  logic          cur_wr, ram_in, ram_hit, mmio_hit;
  logic          accept, resp_entry, rd_entry;
  logic [31:0]   addr_mux, ram_rdata, mmio_data;
  logic [AW-1:0] ram_idx;

  // In IDLE the decode works on the live bus so a zero-wait read can start the RAM at once.
  assign accept   = (state_reg == IDLE) && (d_wr_req || d_rd_req);
  assign cur_wr   = (state_reg == IDLE) ? d_wr_req : req_reg.wr;
  assign addr_mux = (state_reg == IDLE) ? d_addr : req_reg.addr;
  assign ram_in   = ({1'b0, addr_mux} >= {1'b0, BASE}) && ({1'b0, addr_mux} < LIMIT);
  assign ram_hit  = ram_in && !mmio_hit;
  assign ram_idx  = addr_mux[AW+1:2] - BASE[AW+1:2];

  assign resp_entry = (state_reg != RESP) && (state_next == RESP);
  assign rd_entry   = resp_entry && !cur_wr;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = (WAIT_CYC == 0) ? RESP : WAIT;
      WAIT:    if (cnt_reg <= 1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    d_wr_ready = (state_reg == RESP) && req_reg.wr;
    d_rd_ready = (state_reg == RESP) && !req_reg.wr;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_reg    <= '0;
      req_reg    <= '0;
      rd_src_reg <= SRC_ZERO;
      err_reg    <= 1'b0;
    end else begin
      if (accept) begin
        cnt_reg <= WAIT_W'(WAIT_CYC);
        req_reg <= '{wr: d_wr_req, addr: d_addr, be: d_be, data: d_wr_data};
      end else if (state_reg == WAIT) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
      if (rd_entry) rd_src_reg <= ram_hit ? SRC_RAM : (mmio_hit ? SRC_MMIO : SRC_ZERO);
      if ((state_reg == RESP) && !ram_hit && !mmio_hit) err_reg <= 1'b1;
    end
  end

  dmem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    ((state_reg == RESP) && req_reg.wr && ram_hit),
    .re    (rd_entry && ram_hit),
    .addr  (ram_idx),
    .be    (req_reg.be),
    .wdata (req_reg.data),
    .rdata (ram_rdata)
  );

`ifdef DMEM_MMIO_EN
  logic [31:0] cycle_cnt_reg, mmio_snap_reg;

  assign mmio_hit  = (addr_mux[31:2] == MMIO_BASE[31:2]);
  assign mmio_data = mmio_snap_reg;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cycle_cnt_reg <= '0;
      mmio_snap_reg <= '0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (rd_entry && mmio_hit) mmio_snap_reg <= cycle_cnt_reg;
    end
  end
`else
  logic [31:0] unused_mmio_base;
  assign unused_mmio_base = MMIO_BASE;
  assign mmio_hit         = 1'b0;
  assign mmio_data        = '0;
`endif

  // Read data is held in registers (RAM output, source select, counter snapshot) between reads.
  always_comb begin
    case (rd_src_reg)
      SRC_RAM:  d_rd_data = ram_rdata;
      SRC_MMIO: d_rd_data = mmio_data;
      default:  d_rd_data = 32'h0;
    endcase
  end

  assign err_oor = err_reg;
endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: two instances (zero and three wait states) checked against a word-array model.
module tb_dmem_resp;
  localparam logic [31:0] BASE      = 32'h0000_1000;
  localparam int          DEPTH     = 64;
  localparam logic [31:0] MMIO_BASE = 32'h0000_F000;
  localparam int          W0        = 0;
  localparam int          W1        = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstb[2];
  logic [31:0] d_addr[2];
  logic        wr_req[2], rd_req[2];
  logic [3:0]  be[2];
  logic [31:0] wdata[2];
  logic        wr_ready[2], rd_ready[2], err_oor[2];
  logic [31:0] rd_data[2];

  dmem_resp #(.BASE(BASE), .DEPTH(DEPTH), .WAIT_CYC(W0), .MMIO_BASE(MMIO_BASE)) dut0 (
    .clk(clk), .rstb(rstb[0]), .d_addr(d_addr[0]), .d_wr_req(wr_req[0]), .d_wr_ready(wr_ready[0]),
    .d_rd_req(rd_req[0]), .d_rd_ready(rd_ready[0]), .d_be(be[0]), .d_wr_data(wdata[0]),
    .d_rd_data(rd_data[0]), .err_oor(err_oor[0]));

  dmem_resp #(.BASE(BASE), .DEPTH(DEPTH), .WAIT_CYC(W1), .MMIO_BASE(MMIO_BASE)) dut1 (
    .clk(clk), .rstb(rstb[1]), .d_addr(d_addr[1]), .d_wr_req(wr_req[1]), .d_wr_ready(wr_ready[1]),
    .d_rd_req(rd_req[1]), .d_rd_ready(rd_ready[1]), .d_be(be[1]), .d_wr_data(wdata[1]),
    .d_rd_data(rd_data[1]), .err_oor(err_oor[1]));

  int errors = 0;
  int checks = 0;
  logic [31:0] model [2][DEPTH];

  function automatic int wait_of(input int s);
    return (s == 0) ? W0 : W1;
  endfunction

  function automatic bit in_ram(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 4 * DEPTH);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] expect_rd(input int s, input logic [31:0] a);
    return in_ram(a) ? model[s][idx_of(a)] : 32'h0;
  endfunction

  task automatic model_write(input int s, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    logic [31:0] w;
    if (in_ram(a)) begin
      w = model[s][idx_of(a)];
      for (int i = 0; i < 4; i++) if (b[i]) w[8*i +: 8] = d[8*i +: 8];
      model[s][idx_of(a)] = w;
    end
  endtask

  // Issue one request and hold it until the matching ready is sampled (bounded).
  task automatic xact(input int s, input bit wr, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] wd, output logic [31:0] rd, output int lat);
    @(negedge clk);
    d_addr[s] = a; be[s] = b; wdata[s] = wd; wr_req[s] = wr; rd_req[s] = !wr;
    lat = 0;
    do begin
      @(posedge clk); lat++; @(negedge clk);
    end while (!(wr ? wr_ready[s] : rd_ready[s]) && lat < 50);
    rd = rd_data[s];
    wr_req[s] = 1'b0; rd_req[s] = 1'b0;
    $display("xact dut%0d %s addr=%h be=%h wd=%h rd=%h lat=%0d", s, wr ? "WR" : "RD", a, b, wd, rd, lat);
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      rstb[s] = 1'b0; wr_req[s] = 1'b0; rd_req[s] = 1'b0;
      d_addr[s] = '0; be[s] = '0; wdata[s] = '0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) rstb[s] = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++; if (wr_ready[s] !== 1'b0) begin errors++; $display("FAIL reset_wr_ready dut%0d got %b want 0", s, wr_ready[s]); end
      checks++; if (rd_ready[s] !== 1'b0) begin errors++; $display("FAIL reset_rd_ready dut%0d got %b want 0", s, rd_ready[s]); end
      checks++; if (rd_data[s] !== 32'h0) begin errors++; $display("FAIL reset_rd_data dut%0d got %h want 0", s, rd_data[s]); end
      checks++; if (err_oor[s] !== 1'b0) begin errors++; $display("FAIL reset_err_oor dut%0d got %b want 0", s, err_oor[s]); end
    end
  endtask

  task automatic preload();
    logic [31:0] rd, d;
    int lat;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++) begin
        d = $urandom;
        xact(s, 1'b1, BASE + 32'(4 * i), 4'hF, d, rd, lat);
        model_write(s, BASE + 32'(4 * i), 4'hF, d);
      end
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    int lat;
    xact(0, 1'b1, BASE, 4'hF, 32'hDEAD_BEEF, rd, lat);
    model_write(0, BASE, 4'hF, 32'hDEAD_BEEF);
    checks++; if (lat !== 1) begin errors++; $display("FAIL basic_wr_latency got %0d want 1", lat); end
    xact(0, 1'b0, BASE, 4'h0, 32'h0, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL basic_rd_latency got %0d want 1", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_rd_data got %h want deadbeef", rd); end
    xact(0, 1'b1, BASE + 32'd4, 4'hF, 32'h1234_5678, rd, lat);
    model_write(0, BASE + 32'd4, 4'hF, 32'h1234_5678);
    checks++; if (rd_data[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data_hold got %h want deadbeef", rd_data[0]); end
  endtask

  task automatic test_byte_merge();
    logic [31:0] rd;
    int lat;
    xact(0, 1'b1, BASE + 32'd4, 4'hF, 32'h1122_3344, rd, lat);
    model_write(0, BASE + 32'd4, 4'hF, 32'h1122_3344);
    xact(0, 1'b1, BASE + 32'd4, 4'b0101, 32'hAABB_CCDD, rd, lat);
    model_write(0, BASE + 32'd4, 4'b0101, 32'hAABB_CCDD);
    xact(0, 1'b0, BASE + 32'd4, 4'h0, 32'h0, rd, lat);
    checks++; if (rd !== 32'h11BB_33DD) begin errors++; $display("FAIL byte_merge got %h want 11bb33dd", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d;
    logic [3:0] b;
    int lat, s;
    bit wr;
    for (int n = 0; n < 40; n++) begin
      s  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
      b  = 4'($urandom);
      d  = $urandom;
      xact(s, wr, a, b, d, rd, lat);
      checks++; if (lat !== wait_of(s) + 1) begin errors++; $display("FAIL rand_latency dut%0d got %0d want %0d", s, lat, wait_of(s) + 1); end
      if (wr) model_write(s, a, b, d);
      else begin
        checks++; if (rd !== expect_rd(s, a)) begin errors++; $display("FAIL rand_rd_data dut%0d addr %h got %h want %h", s, a, rd, expect_rd(s, a)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int p[3];
    int n, cyc;
    p = '{0, 0, 0}; n = 0; cyc = 0;
    @(negedge clk);
    d_addr[1] = BASE + 32'd16; be[1] = 4'hF; rd_req[1] = 1'b1;
    while (n < 3 && cyc < 60) begin
      @(posedge clk); cyc++; @(negedge clk);
      if (rd_ready[1]) begin
        p[n] = cyc;
        checks++; if (rd_data[1] !== model[1][4]) begin errors++; $display("FAIL b2b_rd_data got %h want %h", rd_data[1], model[1][4]); end
        n++;
        if (n == 3) rd_req[1] = 1'b0;
      end
    end
    rd_req[1] = 1'b0;
    $display("b2b ready pulses at cycles %0d %0d %0d", p[0], p[1], p[2]);
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_pulse_count got %0d want 3", n); end
    checks++; if (p[0] !== W1 + 1) begin errors++; $display("FAIL b2b_first_latency got %0d want %0d", p[0], W1 + 1); end
    checks++; if (p[1] - p[0] !== W1 + 2) begin errors++; $display("FAIL b2b_spacing1 got %0d want %0d", p[1] - p[0], W1 + 2); end
    checks++; if (p[2] - p[1] !== W1 + 2) begin errors++; $display("FAIL b2b_spacing2 got %0d want %0d", p[2] - p[1], W1 + 2); end
  endtask

  task automatic test_both_req();
    logic [1:0] seen[2];
    logic [31:0] rdv;
    int n, cyc;
    n = 0; cyc = 0; rdv = '0;
    seen[0] = 2'b00; seen[1] = 2'b00;
    @(negedge clk);
    d_addr[0] = BASE + 32'd8; be[0] = 4'hF; wdata[0] = 32'h5; wr_req[0] = 1'b1; rd_req[0] = 1'b1;
    while (n < 2 && cyc < 40) begin
      @(posedge clk); cyc++; @(negedge clk);
      if (wr_ready[0] || rd_ready[0]) begin
        seen[n] = {wr_ready[0], rd_ready[0]};
        if (wr_ready[0]) wr_req[0] = 1'b0;
        if (rd_ready[0]) begin rd_req[0] = 1'b0; rdv = rd_data[0]; end
        n++;
      end
    end
    wr_req[0] = 1'b0; rd_req[0] = 1'b0;
    model_write(0, BASE + 32'd8, 4'hF, 32'h5);
    $display("both_req responses %b then %b rd=%h", seen[0], seen[1], rdv);
    checks++; if (seen[0] !== 2'b10) begin errors++; $display("FAIL both_first_is_write got %b want 10", seen[0]); end
    checks++; if (seen[1] !== 2'b01) begin errors++; $display("FAIL both_second_is_read got %b want 01", seen[1]); end
    checks++; if (rdv !== 32'h5) begin errors++; $display("FAIL both_rd_data got %h want 5", rdv); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    int lat;
    checks++; if (err_oor[0] !== 1'b0) begin errors++; $display("FAIL oor_before got %b want 0", err_oor[0]); end
    xact(0, 1'b0, BASE + 32'(4 * DEPTH), 4'hF, 32'h0, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL oor_rd_latency got %0d want 1", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rd_data got %h want 0", rd); end
    @(negedge clk);
    checks++; if (err_oor[0] !== 1'b1) begin errors++; $display("FAIL oor_err_set got %b want 1", err_oor[0]); end
    xact(0, 1'b1, BASE + 32'(4 * DEPTH), 4'hF, 32'h0, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL oor_wr_latency got %0d want 1", lat); end
    xact(0, 1'b0, BASE, 4'hF, 32'h0, rd, lat);
    checks++; if (rd !== model[0][0]) begin errors++; $display("FAIL oor_wr_dropped got %h want %h", rd, model[0][0]); end
    xact(0, 1'b0, BASE - 32'd4, 4'hF, 32'h0, rd, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL below_base_rd got %h want 0", rd); end
    checks++; if (err_oor[0] !== 1'b1) begin errors++; $display("FAIL oor_err_sticky got %b want 1", err_oor[0]); end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd;
    int lat;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    d_addr[1] = BASE + 32'd12; be[1] = 4'hF; wdata[1] = ~model[1][3]; wr_req[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    rstb[1] = 1'b0; wr_req[1] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (wr_ready[1] || rd_ready[1]) seen = 1'b1;
    end
    rstb[1] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (wr_ready[1] || rd_ready[1]) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_abort_ready got %b want 0", seen); end
    checks++; if (rd_data[1] !== 32'h0) begin errors++; $display("FAIL reset_abort_rd_data got %h want 0", rd_data[1]); end
    xact(1, 1'b0, BASE + 32'd12, 4'hF, 32'h0, rd, lat);
    checks++; if (rd !== model[1][3]) begin errors++; $display("FAIL reset_abort_no_commit got %h want %h", rd, model[1][3]); end
  endtask

  task automatic test_mmio();
    logic [31:0] d1, d2, rd;
    int lat;
`ifdef DMEM_MMIO_EN
    xact(1, 1'b0, MMIO_BASE, 4'hF, 32'h0, d1, lat);
    repeat (10 - (W1 + 2)) @(negedge clk);
    xact(1, 1'b0, MMIO_BASE, 4'hF, 32'h0, d2, lat);
    checks++; if (d2 - d1 !== 32'd10) begin errors++; $display("FAIL mmio_delta got %0d want 10", d2 - d1); end
    xact(1, 1'b1, MMIO_BASE, 4'hF, 32'hFFFF_FFFF, rd, lat);
    checks++; if (lat !== W1 + 1) begin errors++; $display("FAIL mmio_wr_latency got %0d want %0d", lat, W1 + 1); end
    @(negedge clk);
    checks++; if (err_oor[1] !== 1'b0) begin errors++; $display("FAIL mmio_wr_err got %b want 0", err_oor[1]); end
`else
    d2 = '0;
    xact(1, 1'b0, MMIO_BASE, 4'hF, 32'h0, d1, lat);
    checks++; if (d1 !== d2) begin errors++; $display("FAIL mmio_absent_rd got %h want 0", d1); end
    @(negedge clk);
    checks++; if (err_oor[1] !== 1'b1) begin errors++; $display("FAIL mmio_absent_err got %b want 1", err_oor[1]); end
    rd = '0;
    if (rd !== 32'h0) $display("unexpected");
`endif
  endtask

  initial begin
    test_reset();
    preload();
    test_basic();
    test_byte_merge();
    test_random();
    test_back_to_back();
    test_both_req();
    test_out_of_range();
    test_reset_in_wait();
    test_mmio();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
